// File: rtl/cache_pkg.sv
// Shared sizes, types and helpers for the cache way array.
// Build with CACHE_ARRAY_PARITY_EN to store an even-parity bit alongside every tag.
package cache_pkg;

    localparam int unsigned NWAY   = 2;
    localparam int unsigned SETS   = 128;
    localparam int unsigned TAG_W  = 20;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned BE_W   = LINE_W / 8;
    localparam int unsigned WAY_W  = (NWAY > 1) ? $clog2(NWAY) : 1;
`ifdef CACHE_ARRAY_PARITY_EN
    localparam int unsigned TMEM_W = TAG_W + 1;
`else
    localparam int unsigned TMEM_W = TAG_W;
`endif

    typedef struct packed {
        logic [WAY_W-1:0]  way;
        logic [IDX_W-1:0]  idx;
        logic              tag_en;
        logic [TAG_W-1:0]  tag;
        logic              vld;
        logic [BE_W-1:0]   be;
        logic [LINE_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } sweep_state_e;

    // Stored tag word: parity bit sits above the tag when enabled.
    function automatic logic [TMEM_W-1:0] tag_encode(input logic [TAG_W-1:0] tag);
`ifdef CACHE_ARRAY_PARITY_EN
        return {^tag, tag};
`else
        return tag;
`endif
    endfunction

    function automatic logic [LINE_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
        logic [LINE_W-1:0] mask;
        for (int b = 0; b < BE_W; b++) begin
            mask[8*b +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/cache_way_bank.sv
// One cache way: tag, valid and byte-enabled data storage with a registered read port.
// Read returns the pre-write contents when reading and writing the same set in one cycle.
module cache_way_bank
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [TMEM_W-1:0] rd_tag,
    output logic              rd_vld,
    output logic [LINE_W-1:0] rd_data,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic              wr_tag_en,
    input  logic [TMEM_W-1:0] wr_tag,
    input  logic              wr_vld,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [LINE_W-1:0] wr_data
);

    logic [TMEM_W-1:0] tag_mem  [SETS];
    logic [SETS-1:0]   vld_mem;
    logic [LINE_W-1:0] data_mem [SETS];

    logic [TMEM_W-1:0] rd_tag_q,  rd_tag_d;
    logic              rd_vld_q,  rd_vld_d;
    logic [LINE_W-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_tag_en) begin
            tag_mem[wr_idx] <= wr_tag;
            vld_mem[wr_idx] <= wr_vld;
        end
        for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) begin
                data_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_tag_d  = rd_tag_q;
        rd_vld_d  = rd_vld_q;
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_tag_d  = tag_mem[rd_idx];
            rd_vld_d  = vld_mem[rd_idx];
            rd_data_d = data_mem[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_tag_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_tag_q  <= rd_tag_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_tag  = rd_tag_q;
    assign rd_vld  = rd_vld_q;
    assign rd_data = rd_data_q;

endmodule

// File: rtl/cache_way_array.sv
// N-way tag/valid/data array with same-cycle write forwarding and a flash-invalidate sweep.
// Define CACHE_ARRAY_PARITY_EN to enable per-way tag parity checking on par_err.
module cache_way_array
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    output logic                   ready,
    input  logic                   rd_en,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [NWAY*TAG_W-1:0]  rd_tag,
    output logic [NWAY-1:0]        rd_vld,
    output logic [NWAY*LINE_W-1:0] rd_data,
    input  logic                   wr_en,
    input  logic [WAY_W-1:0]       wr_way,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic                   wr_tag_en,
    input  logic [TAG_W-1:0]       wr_tag,
    input  logic                   wr_vld,
    input  logic [BE_W-1:0]        wr_be,
    input  logic [LINE_W-1:0]      wr_data,
    input  logic                   inv_req,
    output logic [NWAY-1:0]        par_err
);

    sweep_state_e     state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    wr_req_t          snap_q, snap_d;
    logic             snap_vld_q, snap_vld_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic             blk_q, blk_d;
    logic             sweeping, rd_go, wr_go;

    assign sweeping = (state_q == SWEEP);
    assign ready    = ~sweeping;
    assign rd_go    = rd_en & ready;
    assign wr_go    = wr_en & ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SWEEP: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (inv_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            default: state_d = SWEEP;
        endcase
    end

    // Capture the write issued alongside each accepted read; merged onto the bank outputs.
    always_comb begin
        snap_d     = snap_q;
        snap_vld_d = snap_vld_q;
        rd_idx_d   = rd_idx_q;
        blk_d      = blk_q;
        if (rd_en) begin
            blk_d = ~ready;
        end
        if (rd_go) begin
            rd_idx_d   = rd_idx;
            snap_vld_d = wr_go;
            snap_d     = '{way: wr_way, idx: wr_idx, tag_en: wr_tag_en, tag: wr_tag,
                           vld: wr_vld, be: wr_be, data: wr_data};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= SWEEP;
            cnt_q      <= '0;
            snap_q     <= '0;
            snap_vld_q <= 1'b0;
            rd_idx_q   <= '0;
            blk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            snap_vld_q <= snap_vld_d;
            rd_idx_q   <= rd_idx_d;
            blk_q      <= blk_d;
        end
    end

    for (genvar w = 0; w < NWAY; w++) begin : gen_way
        logic              sel, hit, tag_hit;
        logic [IDX_W-1:0]  b_wr_idx;
        logic              b_wr_tag_en;
        logic [TMEM_W-1:0] b_wr_tag;
        logic [BE_W-1:0]   b_wr_be;
        logic [TMEM_W-1:0] b_tag;
        logic              b_vld;
        logic [LINE_W-1:0] b_data, mask;

        assign sel         = wr_go && (wr_way == WAY_W'(w));
        assign b_wr_idx    = sweeping ? cnt_q : wr_idx;
        assign b_wr_tag_en = sweeping | (sel & wr_tag_en);
        assign b_wr_tag    = sweeping ? tag_encode('0) : tag_encode(wr_tag);
        assign b_wr_be     = sel ? wr_be : '0;

        cache_way_bank u_bank (
            .clk       (clk),
            .rstn      (rstn),
            .rd_en     (rd_go),
            .rd_idx    (rd_idx),
            .rd_tag    (b_tag),
            .rd_vld    (b_vld),
            .rd_data   (b_data),
            .wr_idx    (b_wr_idx),
            .wr_tag_en (b_wr_tag_en),
            .wr_tag    (b_wr_tag),
            .wr_vld    (~sweeping & wr_vld),
            .wr_be     (b_wr_be),
            .wr_data   (wr_data)
        );

        assign hit     = snap_vld_q && (snap_q.way == WAY_W'(w)) && (snap_q.idx == rd_idx_q);
        assign tag_hit = hit & snap_q.tag_en;
        assign mask    = hit ? be_to_mask(snap_q.be) : '0;

        assign rd_tag[w*TAG_W +: TAG_W]   = tag_hit ? snap_q.tag : b_tag[TAG_W-1:0];
        assign rd_vld[w]                  = ~blk_q & (tag_hit ? snap_q.vld : b_vld);
        assign rd_data[w*LINE_W +: LINE_W] = (b_data & ~mask) | (snap_q.data & mask);
`ifdef CACHE_ARRAY_PARITY_EN
        // A forwarded tag was just encoded with fresh parity, so only stored tags can be bad.
        assign par_err[w] = rd_vld[w] & ~tag_hit & (^b_tag);
`else
        assign par_err[w] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_cache_way_array.sv
// Scoreboard bench for cache_way_array: reads push expectations, a monitor checks outputs.
// Parity flip checks apply when built with CACHE_ARRAY_PARITY_EN.
module tb_cache_way_array;
    import cache_pkg::*;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic                   ready;
    logic                   rd_en = 1'b0;
    logic [IDX_W-1:0]       rd_idx = '0;
    logic [NWAY*TAG_W-1:0]  rd_tag;
    logic [NWAY-1:0]        rd_vld;
    logic [NWAY*LINE_W-1:0] rd_data;
    logic                   wr_en = 1'b0;
    logic [WAY_W-1:0]       wr_way = '0;
    logic [IDX_W-1:0]       wr_idx = '0;
    logic                   wr_tag_en = 1'b0;
    logic [TAG_W-1:0]       wr_tag = '0;
    logic                   wr_vld = 1'b0;
    logic [BE_W-1:0]        wr_be = '0;
    logic [LINE_W-1:0]      wr_data = '0;
    logic                   inv_req = 1'b0;
    logic [NWAY-1:0]        par_err;

    cache_way_array dut (
        .clk       (clk),
        .rstn      (rstn),
        .ready     (ready),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_tag    (rd_tag),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_way    (wr_way),
        .wr_idx    (wr_idx),
        .wr_tag_en (wr_tag_en),
        .wr_tag    (wr_tag),
        .wr_vld    (wr_vld),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .inv_req   (inv_req),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    localparam logic [LINE_W-1:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [LINE_W-1:0] D1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [LINE_W-1:0] D2 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    localparam logic [LINE_W-1:0] D3 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [LINE_W-1:0] W3 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_11223344;
    localparam logic [LINE_W-1:0] M3 = 128'hFFEEDDCC_BBAA9988_77665544_11223344;
    localparam logic [BE_W-1:0]   BE_ALL = '1;

    typedef struct {
        string                  name;
        logic [NWAY-1:0]        vld;
        logic [NWAY-1:0]        chk;
        logic [NWAY*TAG_W-1:0]  tag;
        logic [NWAY*LINE_W-1:0] data;
        logic [NWAY-1:0]        par;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: outputs are valid one cycle after an accepted-or-not rd_en.
    always @(posedge clk) begin
        if (rstn && rd_en) begin
            #1;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got read response expected none");
            end else begin
                mon_e = sbq.pop_front();
                check({mon_e.name, "_vld"}, 256'(rd_vld), 256'(mon_e.vld));
                check({mon_e.name, "_par"}, 256'(par_err), 256'(mon_e.par));
                for (int w = 0; w < NWAY; w++) begin
                    if (mon_e.chk[w]) begin
                        check($sformatf("%s_tag%0d", mon_e.name, w),
                              256'(rd_tag[w*TAG_W +: TAG_W]), 256'(mon_e.tag[w*TAG_W +: TAG_W]));
                        check($sformatf("%s_data%0d", mon_e.name, w),
                              256'(rd_data[w*LINE_W +: LINE_W]),
                              256'(mon_e.data[w*LINE_W +: LINE_W]));
                    end
                end
            end
        end
    end

    task automatic push(input string name, input logic [NWAY-1:0] vld, input logic [NWAY-1:0] chk,
                        input logic [NWAY*TAG_W-1:0] tag, input logic [NWAY*LINE_W-1:0] data,
                        input logic [NWAY-1:0] par);
        exp_t e;
        e.name = name; e.vld = vld; e.chk = chk; e.tag = tag; e.data = data; e.par = par;
        sbq.push_back(e);
    endtask

    task automatic set_wr(input logic [WAY_W-1:0] way, input logic [IDX_W-1:0] idx,
                          input logic tag_en, input logic [TAG_W-1:0] tag, input logic vld,
                          input logic [BE_W-1:0] be, input logic [LINE_W-1:0] data);
        wr_en = 1'b1; wr_way = way; wr_idx = idx; wr_tag_en = tag_en;
        wr_tag = tag; wr_vld = vld; wr_be = be; wr_data = data;
    endtask

    task automatic set_rd(input logic [IDX_W-1:0] idx);
        rd_en = 1'b1;
        rd_idx = idx;
    endtask

    task automatic tick();
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
        inv_req = 1'b0;
    endtask

    task automatic count_ready_low(output int n);
        n = 0;
        while (!ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", 256'(ready), 256'(0));
        check("rst_vld", 256'(rd_vld), 256'(0));
        check("rst_tag", 256'(rd_tag), 256'(0));
        check("rst_data", 256'(rd_data), 256'(0));
        check("rst_par", 256'(par_err), 256'(0));

        // Initial sweep
        rstn = 1'b1;
        count_ready_low(n);
        check("init_sweep_len", 256'(n), 256'(SETS));
        set_rd(0);   push("init_rd0", 2'b00, 2'b00, '0, '0, 2'b00);   tick();
        set_rd(5);   push("init_rd5", 2'b00, 2'b00, '0, '0, 2'b00);   tick();
        set_rd(127); push("init_rd127", 2'b00, 2'b00, '0, '0, 2'b00); tick();

        // Write then read next cycle, with a same-cycle write to the other way
        set_wr(1, 5, 1, 20'hABCDE, 1, BE_ALL, D1); tick();
        set_wr(0, 5, 1, 20'h12345, 1, BE_ALL, D0); set_rd(5);
        push("wr_rd5", 2'b11, 2'b11, {20'hABCDE, 20'h12345}, {D1, D0}, 2'b00); tick();
        set_rd(5);
        push("rd5_again", 2'b11, 2'b11, {20'hABCDE, 20'h12345}, {D1, D0}, 2'b00); tick();

        // Byte-merged same-cycle forwarding, tag write disabled
        set_wr(0, 7, 1, 20'h00777, 1, BE_ALL, D2); tick();
        set_wr(0, 7, 0, 20'hFFFFF, 0, 16'h000F, W3); set_rd(7);
        push("fwd_be", 2'b01, 2'b01, {20'h0, 20'h00777}, {D3, M3}, 2'b00); tick();
        set_rd(7);
        push("fwd_be_stored", 2'b01, 2'b01, {20'h0, 20'h00777}, {D3, M3}, 2'b00); tick();
        set_wr(1, 7, 1, 20'h55555, 1, BE_ALL, D3); set_rd(7);
        push("fwd_tag", 2'b11, 2'b11, {20'h55555, 20'h00777}, {D3, M3}, 2'b00); tick();
        set_wr(0, 9, 1, 20'h99999, 1, BE_ALL, D0); set_rd(5);
        push("indep_idx", 2'b11, 2'b11, {20'hABCDE, 20'h12345}, {D1, D0}, 2'b00); tick();
        set_rd(9);
        push("rd9", 2'b01, 2'b01, {20'h0, 20'h99999}, {D3, D0}, 2'b00); tick();
        repeat (3) tick();
        check("hold_vld", 256'(rd_vld), 256'(2'b01));
        check("hold_tag0", 256'(rd_tag[TAG_W-1:0]), 256'(20'h99999));

        // Flash invalidate with ignored write, blocked read and redundant inv_req
        inv_req = 1'b1;
        tick();
        n = 0;
        while (!ready && n < 1000) begin
            n++;
            if (n == 10) set_wr(0, 2, 1, 20'h00222, 1, BE_ALL, D2);
            if (n == 11) begin
                set_rd(5);
                push("rd_in_sweep", 2'b00, 2'b00, '0, '0, 2'b00);
            end
            if (n == 30) inv_req = 1'b1;
            tick();
        end
        check("inv_sweep_len", 256'(n), 256'(SETS));
        set_rd(5); push("post_inv5", 2'b00, 2'b00, '0, '0, 2'b00); tick();
        set_rd(7); push("post_inv7", 2'b00, 2'b00, '0, '0, 2'b00); tick();
        set_rd(2); push("lost_wr2", 2'b00, 2'b00, '0, '0, 2'b00);  tick();
        set_rd(9); push("post_inv9", 2'b00, 2'b00, '0, '0, 2'b00); tick();

        // Tag parity
        set_wr(0, 3, 1, 20'hF0F0F, 1, BE_ALL, D0); tick();
`ifdef CACHE_ARRAY_PARITY_EN
        dut.gen_way[0].u_bank.tag_mem[3][0] = 1'b0;
        set_rd(3);
        push("par_flip", 2'b01, 2'b01, {20'h0, 20'hF0F0E}, {D3, D0}, 2'b01); tick();
`else
        set_rd(3);
        push("par_off", 2'b01, 2'b01, {20'h0, 20'hF0F0F}, {D3, D0}, 2'b00); tick();
`endif

        // Reset asserted mid-sweep
        set_wr(0, 8, 1, 20'h00888, 1, BE_ALL, D2); tick();
        set_rd(8);
        push("pre_rst8", 2'b01, 2'b01, {20'h0, 20'h00888}, {D3, D2}, 2'b00); tick();
        inv_req = 1'b1;
        tick();
        n = 0;
        while (!ready && n < 60) begin
            n++;
            tick();
        end
        check("mid_sweep_ready", 256'(ready), 256'(0));
        check("mid_sweep_hold", 256'(rd_vld), 256'(2'b01));
        rstn = 1'b0;
        #1;
        check("async_rst_vld", 256'(rd_vld), 256'(0));
        check("async_rst_tag", 256'(rd_tag), 256'(0));
        check("async_rst_data", 256'(rd_data), 256'(0));
        check("async_rst_par", 256'(par_err), 256'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        count_ready_low(n);
        check("restart_sweep_len", 256'(n), 256'(SETS));
        set_rd(8); push("post_rst8", 2'b00, 2'b00, '0, '0, 2'b00); tick();

        repeat (3) tick();
        check("sb_drained", 256'(sbq.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
